// File: rtl/fu_br_pipe.sv
// fu_br_pipe: two-stage branch/jump resolve unit with prediction check,
// age-based flush and saturating resolve/mispredict counters.
`ifndef DATA_WIDTH_BR_OP
`define DATA_WIDTH_BR_OP 4
`define BR_OP_BEQ  4'd0
`define BR_OP_BNE  4'd1
`define BR_OP_BLT  4'd2
`define BR_OP_BLTU 4'd3
`define BR_OP_BGE  4'd4
`define BR_OP_BGEU 4'd5
`define BR_OP_JAL  4'd6
`define BR_OP_JALR 4'd7
`endif

module fu_br_pipe #(
  parameter int PC_WIDTH   = 32,
  parameter int WORD_WIDTH = 32,
  parameter int ROB_DEPTH  = 16,
  parameter int CNT_WIDTH  = 16,
  localparam int RW = $clog2(ROB_DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [`DATA_WIDTH_BR_OP-1:0] in_op,
  input  logic [PC_WIDTH-1:0]          in_pc,
  input  logic [WORD_WIDTH-1:0]        in_imm,
  input  logic [WORD_WIDTH-1:0]        in_rs1,
  input  logic [WORD_WIDTH-1:0]        in_rs2,
  input  logic [RW-1:0]                in_rob,
  input  logic                         in_pred_taken,
  input  logic [PC_WIDTH-1:0]          in_pred_target,
  input  logic [RW-1:0]                rob_head,
  input  logic                         flush_en,
  input  logic [RW-1:0]                flush_rob,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [RW-1:0]                out_rob,
  output logic                         out_taken,
  output logic [PC_WIDTH-1:0]          out_redirect_pc,
  output logic                         out_mispredict,
  output logic [WORD_WIDTH-1:0]        out_link,
  output logic                         out_link_valid,
  output logic [CNT_WIDTH-1:0]         cnt_resolved,
  output logic [CNT_WIDTH-1:0]         cnt_mispredict
);
  typedef struct packed {
    logic [RW-1:0]         rob;
    logic                  taken;
    logic [PC_WIDTH-1:0]   redirect;
    logic                  mispredict;
    logic [WORD_WIDTH-1:0] link;
    logic                  link_valid;
  } res_t;

  // Modular age relative to the ROB head, so tag wrap needs no special case.
  function automatic logic younger(input logic [RW-1:0] x, input logic [RW-1:0] h,
                                   input logic [RW-1:0] f);
    logic [RW-1:0] ax, af;
    ax = x - h;
    af = f - h;
    return ax > af;
  endfunction

  logic                  e_valid_q, e_valid_d, w_valid_q, w_valid_d;
  res_t                  e_q, e_d, w_q, w_d, res;
  logic [CNT_WIDTH-1:0]  cnt_res_q, cnt_res_d, cnt_mis_q, cnt_mis_d;
  logic [PC_WIDTH-1:0]   pc4, br_tgt, jr_tgt, tgt;
  logic [WORD_WIDTH-1:0] jr_sum;
  logic                  taken, is_jump, e_live, w_live, w_load, store_in, hs;

  always_comb begin
    pc4     = in_pc + PC_WIDTH'(4);
    br_tgt  = in_pc + in_imm[PC_WIDTH-1:0];
    jr_sum  = in_rs1 + in_imm;
    jr_tgt  = jr_sum[PC_WIDTH-1:0] & ~PC_WIDTH'(1);
    is_jump = in_op == `BR_OP_JAL || in_op == `BR_OP_JALR;
    tgt     = in_op == `BR_OP_JALR ? jr_tgt : br_tgt;
    taken   = is_jump                 ? 1'b1 :
              in_op == `BR_OP_BEQ     ? in_rs1 == in_rs2 :
              in_op == `BR_OP_BNE     ? in_rs1 != in_rs2 :
              in_op == `BR_OP_BLT     ? $signed(in_rs1) < $signed(in_rs2) :
              in_op == `BR_OP_BLTU    ? in_rs1 < in_rs2 :
              in_op == `BR_OP_BGE     ? $signed(in_rs1) >= $signed(in_rs2) :
              in_op == `BR_OP_BGEU    ? in_rs1 >= in_rs2 : 1'b0;
    res.rob        = in_rob;
    res.taken      = taken;
    res.redirect   = taken ? tgt : pc4;
    res.mispredict = (taken != in_pred_taken) || (taken && tgt != in_pred_target);
    res.link       = is_jump ? WORD_WIDTH'(pc4) : '0;
    res.link_valid = is_jump;
  end

  // Flush is applied to stored and incoming entries before the advance decision.
  always_comb begin
    e_live    = e_valid_q && !(flush_en && younger(e_q.rob, rob_head, flush_rob));
    w_live    = w_valid_q && !(flush_en && younger(w_q.rob, rob_head, flush_rob));
    in_ready  = !e_valid_q || !w_valid_q || out_ready;
    out_valid = w_live;
    hs        = w_live && out_ready;
    w_load    = e_live && (!w_live || out_ready);
    store_in  = in_valid && in_ready && !(flush_en && younger(in_rob, rob_head, flush_rob));
    e_valid_d = store_in || (e_live && !w_load);
    e_d       = store_in ? res : e_q;
    w_valid_d = w_load || (w_live && !out_ready);
    w_d       = w_load ? e_q : w_q;
    cnt_res_d = (hs && !(&cnt_res_q)) ? cnt_res_q + CNT_WIDTH'(1) : cnt_res_q;
    cnt_mis_d = (hs && w_q.mispredict && !(&cnt_mis_q)) ? cnt_mis_q + CNT_WIDTH'(1) : cnt_mis_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e_valid_q <= 1'b0;
      w_valid_q <= 1'b0;
      e_q       <= '0;
      w_q       <= '0;
      cnt_res_q <= '0;
      cnt_mis_q <= '0;
    end else begin
      e_valid_q <= e_valid_d;
      w_valid_q <= w_valid_d;
      e_q       <= e_d;
      w_q       <= w_d;
      cnt_res_q <= cnt_res_d;
      cnt_mis_q <= cnt_mis_d;
    end
  end

  assign out_rob         = w_q.rob;
  assign out_taken       = w_q.taken;
  assign out_redirect_pc = w_q.redirect;
  assign out_mispredict  = w_q.mispredict;
  assign out_link        = w_q.link;
  assign out_link_valid  = w_q.link_valid;
  assign cnt_resolved    = cnt_res_q;
  assign cnt_mispredict  = cnt_mis_q;
endmodule

// File: tb/tb_fu_br_pipe.sv
// tb_fu_br_pipe: directed plan scenarios plus random traffic against a
// queue-based scoreboard of in-flight ops.
module tb_fu_br_pipe;
  logic        clk = 0, rst = 1;
  logic        in_valid = 0, in_ready;
  logic [3:0]  in_op = 0;
  logic [31:0] in_pc = 0, in_imm = 0, in_rs1 = 0, in_rs2 = 0, in_pred_target = 0;
  logic [3:0]  in_rob = 0, rob_head = 0, flush_rob = 0;
  logic        in_pred_taken = 0, flush_en = 0;
  logic        out_valid, out_ready = 0, out_taken, out_mispredict, out_link_valid;
  logic [3:0]  out_rob;
  logic [31:0] out_redirect_pc, out_link;
  logic [15:0] cnt_resolved, cnt_mispredict;

  fu_br_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rob(in_rob),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target), .rob_head(rob_head),
    .flush_en(flush_en), .flush_rob(flush_rob), .out_valid(out_valid), .out_ready(out_ready),
    .out_rob(out_rob), .out_taken(out_taken), .out_redirect_pc(out_redirect_pc),
    .out_mispredict(out_mispredict), .out_link(out_link), .out_link_valid(out_link_valid),
    .cnt_resolved(cnt_resolved), .cnt_mispredict(cnt_mispredict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rob;
    logic        taken;
    logic [31:0] redir;
    logic        mis;
    logic [31:0] link;
    logic        lv;
  } res_t;

  res_t q[$];
  int   n_tests = 0, n_fail = 0, m_res = 0, m_mis = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int age(input logic [3:0] x);
    return (int'(x) - int'(rob_head) + 16) % 16;
  endfunction

  function automatic bit young(input logic [3:0] x);
    return age(x) > age(flush_rob);
  endfunction

  function automatic res_t model(input logic [3:0] op, input logic [31:0] pc, imm, rs1, rs2,
                                 input logic [3:0] rob, input logic pt, input logic [31:0] ptg);
    res_t r;
    logic [31:0] tgt;
    logic t;
    tgt = pc + imm;
    case (op)
      0: t = rs1 == rs2;
      1: t = rs1 != rs2;
      2: t = $signed(rs1) < $signed(rs2);
      3: t = rs1 < rs2;
      4: t = $signed(rs1) >= $signed(rs2);
      5: t = rs1 >= rs2;
      6: t = 1;
      7: begin t = 1; tgt = (rs1 + imm) & 32'hFFFF_FFFE; end
      default: t = 0;
    endcase
    r.rob   = rob;
    r.taken = t;
    r.redir = t ? tgt : pc + 4;
    r.mis   = (t != pt) || (t && tgt != ptg);
    r.lv    = op == 6 || op == 7;
    r.link  = r.lv ? pc + 4 : 32'h0;
    return r;
  endfunction

  // Model view of one clock edge; inputs are stable when this runs.
  task automatic step();
    bit rdy;
    res_t e;
    check("cnt_resolved", cnt_resolved, m_res);
    check("cnt_mispredict", cnt_mispredict, m_mis);
    rdy = q.size() < 2 || out_ready;
    check("in_ready", in_ready, rdy);
    if (flush_en)
      for (int i = q.size() - 1; i >= 0; i--) if (young(q[i].rob)) q.delete(i);
    if (q.size() == 0) check("idle_out_valid", out_valid, 0);
    if (out_valid && out_ready) begin
      if (q.size() == 0) check("spurious_out", 1, 0);
      else begin
        e = q.pop_front();
        check("out_rob", out_rob, e.rob);
        check("out_taken", out_taken, e.taken);
        check("out_redirect", out_redirect_pc, e.redir);
        check("out_mispredict", out_mispredict, e.mis);
        check("out_link", out_link, e.link);
        check("out_link_valid", out_link_valid, e.lv);
        if (m_res < 65535) m_res++;
        if (e.mis && m_mis < 65535) m_mis++;
      end
    end
    if (in_valid && rdy && !(flush_en && young(in_rob)))
      q.push_back(model(in_op, in_pc, in_imm, in_rs1, in_rs2, in_rob, in_pred_taken, in_pred_target));
  endtask

  task automatic cycle();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] pc, imm, rs1, rs2,
                       input logic [3:0] rob, input logic pt, input logic [31:0] ptg);
    in_valid = 1; in_op = op; in_pc = pc; in_imm = imm; in_rs1 = rs1; in_rs2 = rs2;
    in_rob = rob; in_pred_taken = pt; in_pred_target = ptg;
  endtask

  task automatic do_reset();
    in_valid = 0; flush_en = 0; out_ready = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    q.delete();
    m_res = 0;
    m_mis = 0;
  endtask

  logic [31:0] hold_pc;
  logic [3:0]  hold_rob;

  initial begin
    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_redirect", out_redirect_pc, 0);
    check("rst_cnt", cnt_resolved, 0);
    do_reset();
    check("rst_in_ready", in_ready, 1);

    // BEQ taken, predicted not taken: two cycles to out_valid
    issue(0, 32'h100, 32'h20, 5, 5, 3, 0, 0);
    cycle();
    in_valid = 0;
    cycle();
    check("beq_latency_valid", out_valid, 1);
    check("beq_taken", out_taken, 1);
    check("beq_redirect", out_redirect_pc, 32'h120);
    check("beq_mis", out_mispredict, 1);
    out_ready = 1;
    cycle();
    check("beq_cnt_mis", cnt_mispredict, 1);

    // JALR with a correct prediction; low bit of target cleared
    issue(7, 32'h200, 4, 32'h1001, 0, 4, 1, 32'h1004);
    cycle();
    in_valid = 0;
    cycle();
    check("jalr_redirect", out_redirect_pc, 32'h1004);
    check("jalr_mis", out_mispredict, 0);
    check("jalr_link", out_link, 32'h204);
    check("jalr_lv", out_link_valid, 1);
    cycle();

    // Signed vs unsigned less-than on 0xFFFFFFFF vs 1
    issue(2, 32'h300, 32'h40, 32'hFFFF_FFFF, 1, 5, 1, 32'h340);
    cycle();
    issue(3, 32'h400, 32'h40, 32'hFFFF_FFFF, 1, 6, 0, 0);
    cycle();
    in_valid = 0;
    check("blt_taken", out_taken, 1);
    cycle();
    check("bltu_taken", out_taken, 0);
    check("bltu_redirect", out_redirect_pc, 32'h404);
    cycle();
    cycle();

    // Backpressure: third op waits until out_ready returns
    out_ready = 0;
    issue(1, 32'h500, 8, 1, 2, 7, 1, 32'h508);
    cycle();
    issue(4, 32'h600, 8, 3, 2, 8, 0, 0);
    cycle();
    issue(6, 32'h700, 32'h10, 0, 0, 9, 1, 32'h710);
    check("bp_in_ready_low", in_ready, 0);
    hold_pc = out_redirect_pc;
    hold_rob = out_rob;
    cycle();
    cycle();
    check("bp_stable_valid", out_valid, 1);
    check("bp_stable_redirect", out_redirect_pc, hold_pc);
    check("bp_stable_rob", out_rob, hold_rob);
    out_ready = 1;
    while (in_valid) begin
      if (in_ready) begin cycle(); in_valid = 0; end
      else cycle();
    end
    for (int i = 0; i < 4; i++) cycle();
    check("bp_drained", q.size(), 0);

    // Flush across tag wrap: head 14, tags 15 and 1, flush point 15
    do_reset();
    rob_head = 14;
    issue(0, 32'h800, 8, 1, 1, 15, 1, 32'h808);
    cycle();
    issue(0, 32'h900, 8, 1, 1, 1, 1, 32'h908);
    cycle();
    in_valid = 0;
    flush_en = 1;
    flush_rob = 15;
    #1;
    check("flush_w_visible", out_valid, 1);
    cycle();
    flush_en = 0;
    out_ready = 1;
    for (int i = 0; i < 4; i++) cycle();
    check("flush_cnt_resolved", cnt_resolved, 1);

    // Reset with two ops in flight
    out_ready = 0;
    issue(6, 32'hA00, 4, 0, 0, 2, 1, 32'hA04);
    cycle();
    issue(6, 32'hB00, 4, 0, 0, 3, 1, 32'hB04);
    cycle();
    in_valid = 0;
    rst = 1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_cnt", cnt_resolved, 0);
    check("midrst_link", out_link, 0);
    q.delete();
    m_res = 0;
    m_mis = 0;
    @(posedge clk);
    #1;
    rst = 0;
    check("midrst_in_ready", in_ready, 1);

    // Random traffic with occasional flushes
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pc, imm;
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 64) - 32;
      in_valid       = $urandom_range(0, 9) < 7;
      in_op          = 4'($urandom_range(0, 9));
      in_pc          = pc;
      in_imm         = imm;
      in_rs1         = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
      in_rs2         = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 3));
      in_rob         = 4'($urandom);
      in_pred_taken  = 1'($urandom);
      in_pred_target = $urandom_range(0, 1) ? pc + imm : $urandom;
      rob_head       = 4'($urandom);
      flush_en       = $urandom_range(0, 7) == 0;
      flush_rob      = 4'($urandom);
      out_ready      = $urandom_range(0, 9) < 6;
      cycle();
    end

    in_valid = 0;
    flush_en = 0;
    out_ready = 1;
    for (int i = 0; i < 50 && q.size() != 0; i++) cycle();
    cycle();
    check("final_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
